// File: rtl/classifier_mac_argmax_modular_pkg.sv
// Shared widths, saturation limits and the saturating add used by the
// output-layer classifier (MAC unit and argmax top).
package classifier_mac_argmax_modular_pkg;

    localparam int unsigned ACC_W  = 20;
    localparam int unsigned X_W    = 4;
    localparam int unsigned W_W    = 8;
    localparam int unsigned PROD_W = 12;

    localparam logic signed [ACC_W-1:0] ACC_MIN = 20'sh80000;  // -524288
    localparam logic signed [ACC_W-1:0] ACC_MAX = 20'sh7FFFF;  // +524287

    // Signed add that clamps to [ACC_MIN, ACC_MAX] instead of wrapping.
    function automatic logic signed [ACC_W-1:0] sat20(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
        logic [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        // The two top bits disagree only when the true result left the 20-bit range.
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            return sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return sum[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/classifier_mac_unit.sv
// Multiply-accumulate for one class score.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   x_int4, w_int8    signed activation / weight
//   new_feat          accumulate x*w this cycle
//   new_class         class end: clear the accumulator
//   acc20             registered running score
//   candidate         combinational finalized score (acc20 + product if new_feat)
module classifier_mac_unit
    import classifier_mac_argmax_modular_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [X_W-1:0]   x_int4,
    input  logic signed [W_W-1:0]   w_int8,
    input  logic                    new_feat,
    input  logic                    new_class,
    output logic signed [ACC_W-1:0] acc20,
    output logic signed [ACC_W-1:0] candidate
);

    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  addend;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    // 4b x 8b always fits in 12 bits, so the product never overflows.
    assign x_ext  = {{(PROD_W - X_W){x_int4[X_W-1]}}, x_int4};
    assign w_ext  = {{(PROD_W - W_W){w_int8[W_W-1]}}, w_int8};
    assign prod   = x_ext * w_ext;
    assign addend = new_feat ? {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod} : '0;

    // Same saturating sum serves as next accumulator and as the finalized score.
    assign candidate = sat20(acc_q, addend);

    always_comb begin
        acc_d = acc_q;
        if (new_class) begin
            acc_d = '0;
        end else if (new_feat) begin
            acc_d = candidate;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc20 = acc_q;

endmodule

// File: rtl/classifier_mac_argmax_modular.sv
// Streaming output-layer classifier: MAC per class plus running argmax.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   x_int4, w_int8       signed activation / weight
//   new_feat             accumulate x*w this cycle
//   new_class, class_id  class end strobe and index of the finalized class
//   acc20                running score of the current class
//   max_score, max_class best score so far and its class index
module classifier_mac_argmax_modular
    import classifier_mac_argmax_modular_pkg::*;
#(
    parameter int unsigned CLASS_BITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [X_W-1:0]   x_int4,
    input  logic signed [W_W-1:0]   w_int8,
    input  logic                    new_feat,
    input  logic                    new_class,
    input  logic [CLASS_BITS-1:0]   class_id,
    output logic signed [ACC_W-1:0] acc20,
    output logic signed [ACC_W-1:0] max_score,
    output logic [CLASS_BITS-1:0]   max_class
);

    logic signed [ACC_W-1:0] candidate;
    logic signed [ACC_W-1:0] max_score_q;
    logic [CLASS_BITS-1:0]   max_class_q;

    classifier_mac_unit u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_int4    (x_int4),
        .w_int8    (w_int8),
        .new_feat  (new_feat),
        .new_class (new_class),
        .acc20     (acc20),
        .candidate (candidate)
    );

    // class_id 0 opens a new inference and overwrites; otherwise strict > keeps
    // the first-seen class on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_score_q <= ACC_MIN;
            max_class_q <= '0;
        end else if (new_class) begin
            if (class_id == '0) begin
                max_score_q <= candidate;
                max_class_q <= '0;
            end else if (candidate > max_score_q) begin
                max_score_q <= candidate;
                max_class_q <= class_id;
            end
        end
    end

    assign max_score = max_score_q;
    assign max_class = max_class_q;

endmodule

// File: tb/tb_classifier_mac_argmax_modular.sv
module tb_classifier_mac_argmax_modular;

    logic               clk;
    logic               rst_n;
    logic signed [3:0]  x_int4;
    logic signed [7:0]  w_int8;
    logic               new_feat;
    logic               new_class;
    logic [2:0]         class_id;
    logic signed [19:0] acc20;
    logic signed [19:0] max_score;
    logic [2:0]         max_class;

    int n_vec;
    int n_bad;

    classifier_mac_argmax_modular #(.CLASS_BITS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_int4    (x_int4),
        .w_int8    (w_int8),
        .new_feat  (new_feat),
        .new_class (new_class),
        .class_id  (class_id),
        .acc20     (acc20),
        .max_score (max_score),
        .max_class (max_class)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic nf, input logic nc, input int x, input int w, input int id);
        @(negedge clk);
        new_feat  = nf;
        new_class = nc;
        x_int4    = 4'(x);
        w_int8    = 8'(w);
        class_id  = 3'(id);
        @(posedge clk);
        #1;
        new_feat  = 1'b0;
        new_class = 1'b0;
    endtask

    task automatic feat(input int x, input int w);
        step(1'b1, 1'b0, x, w, 0);
    endtask

    task automatic fin(input int id);
        step(1'b0, 1'b1, 0, 0, id);
    endtask

    // Three-class stream: scores 260, 61, -396
    task automatic three_class_stream();
        feat(5, 36); feat(3, 69); feat(1, -127); feat(0, -39);
        check("s3_acc_c0", acc20, 260);
        fin(0);
        check("s3_max_c0", max_score, 260);
        check("s3_cls_c0", max_class, 0);
        check("s3_acc_clr", acc20, 0);
        feat(5, 21); feat(3, -13); feat(1, -5); feat(0, -46);
        check("s3_acc_c1", acc20, 61);
        fin(1);
        feat(5, -68); feat(3, -48); feat(1, 88); feat(0, 81);
        check("s3_acc_c2", acc20, -396);
        fin(2);
        check("s3_max_final", max_score, 260);
        check("s3_cls_final", max_class, 0);
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        x_int4    = '0;
        w_int8    = '0;
        new_feat  = 1'b0;
        new_class = 1'b0;
        class_id  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc", acc20, 0);
        check("rst_max", max_score, -524288);
        check("rst_cls", max_class, 0);
        @(negedge clk);
        rst_n = 1'b1;

        three_class_stream();

        // Idle cycle with junk on the data inputs: everything holds
        feat(2, 3);
        step(1'b0, 1'b0, -7, 99, 5);
        check("hold_acc", acc20, 6);
        check("hold_max", max_score, 260);
        fin(0);

        // Later winner, then a tie that must not displace it
        feat(2, 5); fin(0);
        check("lw_max_c0", max_score, 10);
        feat(5, 10); fin(1);
        check("lw_max_c1", max_score, 50);
        check("lw_cls_c1", max_class, 1);
        feat(5, 10); fin(2);
        check("tie_max", max_score, 50);
        check("tie_cls", max_class, 1);

        // Positive saturation: 600 x (+1024)
        for (int i = 0; i < 600; i++) feat(-8, -128);
        check("sat_pos_acc", acc20, 524287);
        fin(0);
        check("sat_pos_max", max_score, 524287);
        check("sat_pos_clr", acc20, 0);

        // Negative saturation: 600 x (-1016); loses to the saturated max
        for (int i = 0; i < 600; i++) feat(-8, 127);
        check("sat_neg_acc", acc20, -524288);
        fin(3);
        check("sat_neg_max", max_score, 524287);
        check("sat_neg_cls", max_class, 0);

        // Simultaneous feature and class end: 100 + 2*5
        feat(4, 25);
        check("sim_acc_pre", acc20, 100);
        step(1'b1, 1'b1, 2, 5, 0);
        check("sim_max", max_score, 110);
        check("sim_acc_clr", acc20, 0);

        // Simultaneous with nonzero id beating the current max
        feat(4, 25);
        step(1'b1, 1'b1, 1, 1, 4);
        check("sim_id4_max", max_score, 110);
        check("sim_id4_cls", max_class, 0);
        feat(4, 25);
        step(1'b1, 1'b1, 3, 5, 6);
        check("sim_id6_max", max_score, 115);
        check("sim_id6_cls", max_class, 6);

        // New inference overwrites even with a lower score
        feat(5, 36); feat(3, 69); feat(1, -127); fin(0);
        check("ni_max_260", max_score, 260);
        feat(1, -5); fin(0);
        check("ni_max_neg", max_score, -5);
        check("ni_cls", max_class, 0);

        // Async reset mid-class, away from any clock edge
        feat(3, 3);
        check("ar_acc_pre", acc20, 9);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_acc", acc20, 0);
        check("ar_max", max_score, -524288);
        check("ar_cls", max_class, 0);
        @(negedge clk);
        rst_n = 1'b1;
        feat(-3, 7); fin(1);
        check("ar_after_max", max_score, -21);
        check("ar_after_cls", max_class, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
